chip8_sprite_drawer: RTL and testbench

// - Initiator side of the chip8_memory video port: executes CHIP-8 DXYN. Fetches N sprite bytes from
//   RAM at I, XORs them into the 64x32 1bpp VRAM (8 bytes/row, MSB = leftmost pixel), reports collision.
// - Sits between the processor (start/done) and the memory video port; one request in flight max.

---
 rtl/chip8_sprite_drawer_pkg.sv | 26 ++
 rtl/chip8_sprite_drawer_if.sv | 21 ++
 rtl/chip8_sprite_drawer.sv | 181 ++++++++++++++++++
 tb/tb_chip8_sprite_drawer.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chip8_sprite_drawer_pkg.sv
// Shared constants and FSM state type for the CHIP-8 sprite drawer and its video port.
package chip8_sprite_drawer_pkg;

  localparam logic VIDEO_MEM_TYPE_RAM  = 1'b0;
  localparam logic VIDEO_MEM_TYPE_VRAM = 1'b1;
  localparam int unsigned VIDEO_MEM_TYPE_COUNT = 2;

  localparam int unsigned SCREEN_W       = 64;
  localparam int unsigned SCREEN_H       = 32;
  localparam int unsigned VRAM_ROW_BYTES = 8;

  typedef enum logic [3:0] {
    StIdle,
    StSprRq,
    StSprWt,
    StLRq,
    StLWt,
    StLWr,
    StRRq,
    StRWt,
    StRWr,
    StNext,
    StDone
  } spr_state_e;

endpackage

// File: rtl/chip8_sprite_drawer_if.sv
// Video port between the sprite drawer (master) and the chip8 memory (slave).
interface chip8_sprite_drawer_if;
  logic [15:0] video_addr_out;
  logic        video_we_out;
  logic        video_valid_out;
  logic [15:0] video_data_out;
  logic        video_type_out;
  logic        video_ready_in;
  logic        video_valid_in;
  logic [15:0] data_in;

  modport master (
    output video_addr_out, video_we_out, video_valid_out, video_data_out, video_type_out,
    input  video_ready_in, video_valid_in, data_in
  );

  modport slave (
    input  video_addr_out, video_we_out, video_valid_out, video_data_out, video_type_out,
    output video_ready_in, video_valid_in, data_in
  );
endinterface

// File: rtl/chip8_sprite_drawer.sv
// CHIP-8 DXYN engine: fetches sprite rows from RAM and XORs them into the 64x32 VRAM,
// one memory request in flight at a time.
module chip8_sprite_drawer
  import chip8_sprite_drawer_pkg::*;
#(
  parameter bit CLIP = 1'b1
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        start_in,
  input  logic [7:0]  x_in,
  input  logic [7:0]  y_in,
  input  logic [3:0]  n_in,
  input  logic [11:0] i_addr_in,
  output logic        busy_out,
  output logic        done_out,
  output logic        collision_out,
  chip8_sprite_drawer_if.master vid
);

  spr_state_e  state_q, state_d;
  logic [5:0]  x_q, x_d;
  logic [4:0]  y_q, y_d;
  logic [3:0]  n_q, n_d;
  logic [11:0] i_q, i_d;
  logic [3:0]  r_q, r_d;
  logic [7:0]  spr_q, spr_d;
  logic [7:0]  old_q, old_d;
  logic        coll_q, coll_d;

  logic [5:0]  y_sum;
  logic [4:0]  ya;
  logic [2:0]  xb, xo;
  logic [15:0] shifted;
  logic [7:0]  l_byte, r_byte;
  logic [7:0]  left_addr, right_addr;
  logic [11:0] spr_addr;
  logic [3:0]  r_inc;
  logic        has_right, next_clip;

  always_comb begin
    y_sum      = {1'b0, y_q} + {2'b00, r_q};
    ya         = y_sum[4:0];
    xb         = x_q[5:3];
    xo         = x_q[2:0];
    shifted    = {spr_q, 8'h00} >> xo;
    l_byte     = shifted[15:8];
    r_byte     = shifted[7:0];
    left_addr  = {ya, xb};
    // 3-bit column wrap lands on byte 0 of the same row when unclipped.
    right_addr = {ya, xb + 3'd1};
    spr_addr   = i_q + {8'h00, r_q};
    r_inc      = r_q + 4'd1;
    has_right  = (xo != 3'd0) && !(CLIP && (xb == 3'd7));
    next_clip  = CLIP && (({1'b0, y_q} + {2'b00, r_inc}) >= 6'(SCREEN_H));
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    n_d     = n_q;
    i_d     = i_q;
    r_d     = r_q;
    spr_d   = spr_q;
    old_d   = old_q;
    coll_d  = coll_q;

    vid.video_valid_out = 1'b0;
    vid.video_we_out    = 1'b0;
    vid.video_addr_out  = 16'h0000;
    vid.video_data_out  = 16'h0000;
    vid.video_type_out  = VIDEO_MEM_TYPE_RAM;

    unique case (state_q)
      StIdle: begin
        if (start_in) begin
          x_d     = x_in[5:0];
          y_d     = y_in[4:0];
          n_d     = n_in;
          i_d     = i_addr_in;
          r_d     = 4'd0;
          coll_d  = 1'b0;
          state_d = (n_in == 4'd0) ? StDone : StSprRq;
        end
      end
      StSprRq: begin
        vid.video_valid_out = 1'b1;
        vid.video_addr_out  = {4'h0, spr_addr};
        if (vid.video_ready_in) state_d = StSprWt;
      end
      StSprWt: begin
        if (vid.video_valid_in) begin
          spr_d   = vid.data_in[7:0];
          state_d = StLRq;
        end
      end
      StLRq: begin
        vid.video_valid_out = 1'b1;
        vid.video_type_out  = VIDEO_MEM_TYPE_VRAM;
        vid.video_addr_out  = {8'h00, left_addr};
        if (vid.video_ready_in) state_d = StLWt;
      end
      StLWt: begin
        if (vid.video_valid_in) begin
          old_d   = vid.data_in[7:0];
          state_d = StLWr;
        end
      end
      StLWr: begin
        vid.video_valid_out = 1'b1;
        vid.video_we_out    = 1'b1;
        vid.video_type_out  = VIDEO_MEM_TYPE_VRAM;
        vid.video_addr_out  = {8'h00, left_addr};
        vid.video_data_out  = {8'h00, old_q ^ l_byte};
        if (vid.video_ready_in) begin
          coll_d  = coll_q | (|(old_q & l_byte));
          state_d = has_right ? StRRq : StNext;
        end
      end
      StRRq: begin
        vid.video_valid_out = 1'b1;
        vid.video_type_out  = VIDEO_MEM_TYPE_VRAM;
        vid.video_addr_out  = {8'h00, right_addr};
        if (vid.video_ready_in) state_d = StRWt;
      end
      StRWt: begin
        if (vid.video_valid_in) begin
          old_d   = vid.data_in[7:0];
          state_d = StRWr;
        end
      end
      StRWr: begin
        vid.video_valid_out = 1'b1;
        vid.video_we_out    = 1'b1;
        vid.video_type_out  = VIDEO_MEM_TYPE_VRAM;
        vid.video_addr_out  = {8'h00, right_addr};
        vid.video_data_out  = {8'h00, old_q ^ r_byte};
        if (vid.video_ready_in) begin
          coll_d  = coll_q | (|(old_q & r_byte));
          state_d = StNext;
        end
      end
      StNext: begin
        r_d     = r_inc;
        state_d = ((r_inc == n_q) || next_clip) ? StDone : StSprRq;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= StIdle;
      x_q     <= '0;
      y_q     <= '0;
      n_q     <= '0;
      i_q     <= '0;
      r_q     <= '0;
      spr_q   <= '0;
      old_q   <= '0;
      coll_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      n_q     <= n_d;
      i_q     <= i_d;
      r_q     <= r_d;
      spr_q   <= spr_d;
      old_q   <= old_d;
      coll_q  <= coll_d;
    end
  end

  assign busy_out      = (state_q != StIdle) && (state_q != StDone);
  assign done_out      = (state_q == StDone);
  assign collision_out = coll_q;

endmodule

// File: tb/tb_chip8_sprite_drawer.sv
// Bench for chip8_sprite_drawer: instance 0 clips, instance 1 wraps; a pixel-level DXYN model
// predicts VRAM, collision and memory traffic while a latency-randomising memory serves requests.
module tb_chip8_sprite_drawer;
  import chip8_sprite_drawer_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst    [2];
  logic        start  [2];
  logic [7:0]  xv     [2];
  logic [7:0]  yv     [2];
  logic [3:0]  nv     [2];
  logic [11:0] iv     [2];
  logic        busy   [2];
  logic        done   [2];
  logic        coll   [2];
  logic        rdy    [2];
  logic        vin    [2];
  logic [15:0] din    [2];
  logic [15:0] m_addr [2];
  logic [15:0] m_data [2];
  logic        m_we   [2];
  logic        m_valid[2];
  logic        m_type [2];

  genvar g;
  generate
    for (g = 0; g < 2; g++) begin : gen_dut
      chip8_sprite_drawer_if vif ();
      assign vif.video_ready_in = rdy[g];
      assign vif.video_valid_in = vin[g];
      assign vif.data_in        = din[g];
      assign m_addr[g]          = vif.video_addr_out;
      assign m_data[g]          = vif.video_data_out;
      assign m_we[g]            = vif.video_we_out;
      assign m_valid[g]         = vif.video_valid_out;
      assign m_type[g]          = vif.video_type_out;

      chip8_sprite_drawer #(.CLIP(g == 0)) u_dut (
        .clk_in       (clk),
        .rst_in       (rst[g]),
        .start_in     (start[g]),
        .x_in         (xv[g]),
        .y_in         (yv[g]),
        .n_in         (nv[g]),
        .i_addr_in    (iv[g]),
        .busy_out     (busy[g]),
        .done_out     (done[g]),
        .collision_out(coll[g]),
        .vid          (vif)
      );
    end
  endgenerate

  logic [7:0] ram     [2][4096];
  logic [7:0] vram    [2][256];
  logic [7:0] exp_vram[2][256];

  int checks = 0;
  int errors = 0;

  // Memory model state (serves one instance at a time).
  bit         pend, inject, rand_rdy, rand_delay, stall_arm, saw_vram_rd;
  int         cnt, fix_delay, stall_left, rd_ram, wr_cnt;
  logic [7:0] resp;
  logic [15:0] snap_addr, snap_data;
  logic        snap_we, snap_type;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int k);
    @(negedge clk);
    vin[k] = 1'b0;
    if (inject) begin
      vin[k] = 1'b1;
      din[k] = 16'h00FF;
    end else if (pend) begin
      if (cnt == 0) begin
        vin[k] = 1'b1;
        din[k] = {8'($urandom), resp};
        pend   = 1'b0;
      end else begin
        cnt--;
      end
    end
    if (stall_arm && m_valid[k]) begin
      snap_addr  = m_addr[k];
      snap_data  = m_data[k];
      snap_we    = m_we[k];
      snap_type  = m_type[k];
      stall_arm  = 1'b0;
      stall_left = 5;
    end
    if (stall_left > 0) begin
      if (stall_left < 5) begin
        chk("stall_valid", m_valid[k], 1);
        chk("stall_addr", m_addr[k], snap_addr);
        chk("stall_we", m_we[k], snap_we);
        chk("stall_data", m_data[k], snap_data);
        chk("stall_type", m_type[k], snap_type);
      end
      rdy[k] = 1'b0;
      stall_left--;
    end else begin
      rdy[k] = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
    if (m_valid[k] && rdy[k]) begin
      if (m_we[k]) begin
        chk("wr_type", m_type[k], 1);
        chk("wr_hi", m_data[k][15:8], 0);
        vram[k][m_addr[k][7:0]] = m_data[k][7:0];
        wr_cnt++;
      end else begin
        pend = 1'b1;
        cnt  = rand_delay ? $urandom_range(0, 4) : fix_delay;
        if (m_type[k]) begin
          resp        = vram[k][m_addr[k][7:0]];
          saw_vram_rd = 1'b1;
        end else begin
          resp = ram[k][m_addr[k][11:0]];
          rd_ram++;
        end
      end
    end
  endtask

  // Pixel-level DXYN: each set sprite bit toggles one screen pixel.
  task automatic ref_draw(input int k, input logic [7:0] x, input logic [7:0] y,
                          input logic [3:0] n, input logic [11:0] i,
                          output bit c, output int rows, output int wr);
    int xx, yy, px, py, idx, bt;
    logic [7:0] s;
    bit clip;
    clip = (k == 0);
    xx = int'(x) % 64;
    yy = int'(y) % 32;
    c = 1'b0; rows = 0; wr = 0;
    for (int r = 0; r < int'(n); r++) begin
      if (clip && (yy + r) >= 32) break;
      rows++;
      wr += ((xx % 8) != 0 && !(clip && (xx / 8) == 7)) ? 2 : 1;
      s = ram[k][(int'(i) + r) % 4096];
      for (int b = 0; b < 8; b++) begin
        if (s[7-b]) begin
          px = xx + b;
          py = (yy + r) % 32;
          if (!(clip && px >= 64)) begin
            px  = px % 64;
            idx = py * 8 + px / 8;
            bt  = 7 - (px % 8);
            if (exp_vram[k][idx][bt]) c = 1'b1;
            exp_vram[k][idx][bt] = ~exp_vram[k][idx][bt];
          end
        end
      end
    end
  endtask

  task automatic clear_vram(input int k);
    for (int a = 0; a < 256; a++) begin
      vram[k][a]     = 8'h00;
      exp_vram[k][a] = 8'h00;
    end
  endtask

  task automatic do_draw(input int k, input logic [7:0] x, input logic [7:0] y,
                         input logic [3:0] n, input logic [11:0] i, input bit start_at_done,
                         input string tag);
    bit ec;
    int er, ew, cyc, mism;
    ref_draw(k, x, y, n, i, ec, er, ew);
    rd_ram = 0; wr_cnt = 0;
    xv[k] = x; yv[k] = y; nv[k] = n; iv[k] = i;
    start[k] = 1'b1;
    step(k);
    start[k] = 1'b0;
    chk({tag, "_busy"}, busy[k], (n != 0));
    cyc = 0;
    while (!done[k] && cyc < 4000) begin
      step(k);
      cyc++;
    end
    chk({tag, "_done"}, done[k], 1);
    chk({tag, "_busy_at_done"}, busy[k], 0);
    chk({tag, "_coll"}, coll[k], ec);
    chk({tag, "_ram_reads"}, rd_ram, er);
    chk({tag, "_writes"}, wr_cnt, ew);
    mism = 0;
    for (int a = 0; a < 256; a++) if (vram[k][a] !== exp_vram[k][a]) mism++;
    chk({tag, "_vram_mismatches"}, mism, 0);
    if (start_at_done) begin
      start[k] = 1'b1;
      step(k);
      start[k] = 1'b0;
      step(k);
      chk({tag, "_start_at_done_busy"}, busy[k], 0);
      chk({tag, "_start_at_done_reads"}, rd_ram, er);
    end else begin
      step(k);
      chk({tag, "_coll_held"}, coll[k], ec);
    end
  endtask

  initial begin
    int cyc, mism;
    bit saw_done;
    pend = 0; inject = 0; rand_rdy = 0; rand_delay = 0; stall_arm = 0; saw_vram_rd = 0;
    cnt = 0; fix_delay = 0; stall_left = 0; rd_ram = 0; wr_cnt = 0; resp = 8'h00;
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1; start[k] = 1'b0; xv[k] = 8'h00; yv[k] = 8'h00; nv[k] = 4'h0;
      iv[k] = 12'h000; rdy[k] = 1'b0; vin[k] = 1'b0; din[k] = 16'h0000;
      for (int a = 0; a < 4096; a++) ram[k][a] = 8'h00;
      clear_vram(k);
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst_valid", m_valid[k], 0);
      chk("rst_busy", busy[k], 0);
      chk("rst_done", done[k], 0);
      chk("rst_coll", coll[k], 0);
      chk("rst_addr", m_addr[k], 0);
      chk("rst_we", m_we[k], 0);
      chk("rst_data", m_data[k], 0);
      chk("rst_type", m_type[k], 0);
      rst[k] = 1'b0;
    end
    @(negedge clk);

    ram[0][12'h050] = 8'hF0;
    do_draw(0, 8'd0, 8'd0, 4'd1, 12'h050, 1'b0, "origin");
    ram[0][12'h100] = 8'hFF;
    do_draw(0, 8'd3, 8'd2, 4'd1, 12'h100, 1'b0, "split1");
    do_draw(0, 8'd3, 8'd2, 4'd1, 12'h100, 1'b0, "split2");

    clear_vram(0);
    ram[0][12'h200] = 8'hFF; ram[0][12'h201] = 8'hFF;
    do_draw(0, 8'd60, 8'd31, 4'd2, 12'h200, 1'b0, "clip_corner");
    ram[1][12'h200] = 8'hFF; ram[1][12'h201] = 8'hFF;
    do_draw(1, 8'd60, 8'd31, 4'd2, 12'h200, 1'b0, "wrap_corner");

    ram[1][12'h100] = 8'hA5; ram[1][12'h101] = 8'h3C; ram[1][12'h102] = 8'h81;
    fix_delay = 7; stall_arm = 1'b1;
    do_draw(1, 8'h43, 8'h22, 4'd3, 12'h100, 1'b0, "stall_x43");
    fix_delay = 0;

    do_draw(0, 8'd10, 8'd10, 4'd0, 12'h100, 1'b1, "n_zero");
    do_draw(0, 8'd20, 8'd5, 4'd1, 12'h100, 1'b1, "start_at_done");

    // Reset while waiting on the left VRAM read, then a stale response.
    clear_vram(0);
    ram[0][12'h300] = 8'hAA;
    fix_delay = 7; saw_vram_rd = 1'b0; wr_cnt = 0;
    xv[0] = 8'd5; yv[0] = 8'd5; nv[0] = 4'd1; iv[0] = 12'h300;
    start[0] = 1'b1;
    step(0);
    start[0] = 1'b0;
    cyc = 0;
    while (!saw_vram_rd && cyc < 200) begin
      step(0);
      cyc++;
    end
    chk("rst_mid_reach_lwt", saw_vram_rd, 1);
    step(0);
    rst[0] = 1'b1;
    pend = 1'b0;
    step(0);
    rst[0] = 1'b0;
    inject = 1'b1;
    step(0);
    inject = 1'b0;
    saw_done = 1'b0;
    for (int c = 0; c < 12; c++) begin
      step(0);
      if (done[0] || m_valid[0]) saw_done = 1'b1;
    end
    chk("rst_mid_no_activity", saw_done, 0);
    chk("rst_mid_writes", wr_cnt, 0);
    chk("rst_mid_busy", busy[0], 0);
    chk("rst_mid_coll", coll[0], 0);
    chk("rst_mid_addr", m_addr[0], 0);
    mism = 0;
    for (int a = 0; a < 256; a++) if (vram[0][a] !== 8'h00) mism++;
    chk("rst_mid_vram", mism, 0);
    fix_delay = 0;
    do_draw(0, 8'd5, 8'd5, 4'd1, 12'h300, 1'b0, "after_rst");

    rand_rdy = 1'b1; rand_delay = 1'b1;
    for (int k = 0; k < 2; k++)
      for (int a = 0; a < 4096; a++) ram[k][a] = 8'($urandom);
    for (int t = 0; t < 24; t++) begin
      do_draw(t % 2, 8'($urandom), 8'($urandom), 4'($urandom), 12'($urandom), 1'b0, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
